// File: rtl/karatsuba_sched_if.sv
// Handshake bundle for the signed Karatsuba sequencer: operand request, result
// reporting, and the link to the shared unsigned half-width multiplier.
interface karatsuba_sched_if #(
    parameter int WIDTH = 8
);
    localparam int H = WIDTH / 2;

    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic                 sinal;
    logic [3:0]           state;
    logic                 mul_go;
    logic [H:0]           mul_x;
    logic [H:0]           mul_y;
    logic [2*H+1:0]       mul_p;
    logic                 mul_done;

    modport master (
        output start, a, b, mul_p, mul_done,
        input  busy, done, product, sinal, state, mul_go, mul_x, mul_y
    );

    modport slave (
        input  start, a, b, mul_p, mul_done,
        output busy, done, product, sinal, state, mul_go, mul_x, mul_y
    );
endinterface

// File: rtl/karatsuba_sched.sv
// Signed Karatsuba multiplier sequencer: sign/magnitude split, three partial
// products through one shared external multiplier, recombination and sign restore.
module karatsuba_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    karatsuba_sched_if.slave bus
);
    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * H + 2;
    localparam int MW = 2 * WIDTH + 1;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ABS      = 4'd1,
        S_ISS_HH   = 4'd2,
        S_WAIT_HH  = 4'd3,
        S_ISS_LL   = 4'd4,
        S_WAIT_LL  = 4'd5,
        S_ISS_MID  = 4'd6,
        S_WAIT_MID = 4'd7,
        S_COMBINE  = 4'd8,
        S_SIGNFIX  = 4'd9,
        S_DONE     = 4'd10
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   ma_r;
    logic [WIDTH-1:0]   mb_r;
    logic [WIDTH-1:0]   abs_a_s;
    logic [WIDTH-1:0]   abs_b_s;
    logic [WIDTH-1:0]   ma_src_s;
    logic [WIDTH-1:0]   mb_src_s;
    logic [PW-1:0]      phh_r;
    logic [PW-1:0]      pll_r;
    logic [PW-1:0]      pm_r;
    logic [MW-1:0]      z1_s;
    logic [MW-1:0]      mag_s;
    logic [2*WIDTH-1:0] mag_r;
    logic [2*WIDTH-1:0] signed_s;
    logic [2*WIDTH-1:0] product_r;
    logic               sinal_r;
    logic               busy_r;
    logic               done_r;
    logic               mul_go_r;
    logic [H:0]         mul_x_r;
    logic [H:0]         mul_y_r;
    logic [H:0]         x_next_s;
    logic [H:0]         y_next_s;

    // Two's-complement magnitude; the most negative value maps onto 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            abs_val = ~v + WIDTH'(1);
        end else begin
            abs_val = v;
        end
    endfunction

    function automatic logic [H:0] half_sum(input logic [WIDTH-1:0] v);
        half_sum = {1'b0, v[WIDTH-1:H]} + {1'b0, v[H-1:0]};
    endfunction

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; multiplier results are only honoured in WAIT states.
    always_comb begin
        state_next_s = S_IDLE;
        case (state_r)
            S_IDLE:     state_next_s = bus.start ? S_ABS : S_IDLE;
            S_ABS:      state_next_s = S_ISS_HH;
            S_ISS_HH:   state_next_s = S_WAIT_HH;
            S_WAIT_HH:  state_next_s = bus.mul_done ? S_ISS_LL : S_WAIT_HH;
            S_ISS_LL:   state_next_s = S_WAIT_LL;
            S_WAIT_LL:  state_next_s = bus.mul_done ? S_ISS_MID : S_WAIT_LL;
            S_ISS_MID:  state_next_s = S_WAIT_MID;
            S_WAIT_MID: state_next_s = bus.mul_done ? S_COMBINE : S_WAIT_MID;
            S_COMBINE:  state_next_s = S_SIGNFIX;
            S_SIGNFIX:  state_next_s = S_DONE;
            S_DONE:     state_next_s = S_IDLE;
            default:    state_next_s = S_IDLE;
        endcase
    end

    // Operands are registered against the next state, so on the ABS->ISS_HH
    // edge the freshly computed magnitudes must be used instead of ma_r/mb_r.
    always_comb begin
        abs_a_s = abs_val(a_r);
        abs_b_s = abs_val(b_r);
        if (state_r == S_ABS) begin
            ma_src_s = abs_a_s;
            mb_src_s = abs_b_s;
        end else begin
            ma_src_s = ma_r;
            mb_src_s = mb_r;
        end
        x_next_s = '0;
        y_next_s = '0;
        case (state_next_s)
            S_ISS_HH, S_WAIT_HH: begin
                x_next_s = {1'b0, ma_src_s[WIDTH-1:H]};
                y_next_s = {1'b0, mb_src_s[WIDTH-1:H]};
            end
            S_ISS_LL, S_WAIT_LL: begin
                x_next_s = {1'b0, ma_src_s[H-1:0]};
                y_next_s = {1'b0, mb_src_s[H-1:0]};
            end
            S_ISS_MID, S_WAIT_MID: begin
                x_next_s = half_sum(ma_src_s);
                y_next_s = half_sum(mb_src_s);
            end
            default: begin
                x_next_s = '0;
                y_next_s = '0;
            end
        endcase
    end

    // Karatsuba recombination and sign restoration.
    always_comb begin
        z1_s  = MW'(pm_r) - MW'(phh_r) - MW'(pll_r);
        mag_s = (MW'(phh_r) << WIDTH) + (z1_s << H) + MW'(pll_r);
        if (sinal_r) begin
            signed_s = (2*WIDTH)'(0) - mag_r;
        end else begin
            signed_s = mag_r;
        end
    end

    // Datapath registers, loaded according to the current state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_r       <= '0;
            b_r       <= '0;
            ma_r      <= '0;
            mb_r      <= '0;
            phh_r     <= '0;
            pll_r     <= '0;
            pm_r      <= '0;
            mag_r     <= '0;
            product_r <= '0;
            sinal_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        a_r <= bus.a;
                        b_r <= bus.b;
                    end
                end
                S_ABS: begin
                    ma_r    <= abs_a_s;
                    mb_r    <= abs_b_s;
                    sinal_r <= a_r[WIDTH-1] ^ b_r[WIDTH-1];
                end
                S_WAIT_HH: begin
                    if (bus.mul_done) phh_r <= bus.mul_p;
                end
                S_WAIT_LL: begin
                    if (bus.mul_done) pll_r <= bus.mul_p;
                end
                S_WAIT_MID: begin
                    if (bus.mul_done) pm_r <= bus.mul_p;
                end
                S_COMBINE: mag_r     <= (2*WIDTH)'(mag_s);
                S_SIGNFIX: product_r <= signed_s;
                default: ;
            endcase
        end
    end

    // Status and multiplier-interface outputs, registered against the next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            mul_go_r <= 1'b0;
            mul_x_r  <= '0;
            mul_y_r  <= '0;
        end else begin
            busy_r   <= (state_next_s != S_IDLE);
            done_r   <= (state_next_s == S_DONE);
            mul_go_r <= (state_next_s == S_ISS_HH) || (state_next_s == S_ISS_LL) ||
                        (state_next_s == S_ISS_MID);
            mul_x_r  <= x_next_s;
            mul_y_r  <= y_next_s;
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;
    assign bus.sinal   = sinal_r;
    assign bus.state   = state_r;
    assign bus.mul_go  = mul_go_r;
    assign bus.mul_x   = mul_x_r;
    assign bus.mul_y   = mul_y_r;
endmodule

// File: tb/tb_karatsuba_sched.sv
// Self-checking bench for karatsuba_sched: directed and randomized signed
// operand pairs against a plain-arithmetic reference, with a latency-programmable multiplier.
module tb_karatsuba_sched;
    localparam int WIDTH = 8;
    localparam int H     = WIDTH / 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    karatsuba_sched_if #(.WIDTH(WIDTH)) bus();

    karatsuba_sched #(.WIDTH(WIDTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "/state"},   64'(bus.state),   64'd0);
        chk({tag, "/busy"},    64'(bus.busy),    64'd0);
        chk({tag, "/done"},    64'(bus.done),    64'd0);
        chk({tag, "/product"}, 64'(bus.product), 64'd0);
        chk({tag, "/sinal"},   64'(bus.sinal),   64'd0);
        chk({tag, "/mul_go"},  64'(bus.mul_go),  64'd0);
        chk({tag, "/mul_xy"},  64'({bus.mul_x, bus.mul_y}), 64'd0);
    endtask

    // One operation: issue start, act as the shared multiplier with the given
    // latencies, then compare against the signed reference.  A non-negative
    // abort_state drops reset_n as soon as that state is observed.
    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input int lhh, input int lll, input int lmid,
                          input bit spur, input bit pulse, input int abort_state);
        int lat[3];
        int ex[3];
        int ey[3];
        int gx[3];
        int gy[3];
        int nops = 0;
        int done_cyc = -1;
        int wcnt = 0;
        int cur_l = 0;
        bit pending = 1'b0;
        bit busy_bad = 1'b0;
        bit stable_bad = 1'b0;
        bit idle_bad = 1'b0;
        int sa;
        int sb;
        int ma;
        int mb;
        logic [15:0] pexp;
        logic sexp;

        lat = '{lhh, lll, lmid};
        sa = int'($signed(a));
        sb = int'($signed(b));
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        ex = '{ma / (1 << H), ma % (1 << H), ma / (1 << H) + ma % (1 << H)};
        ey = '{mb / (1 << H), mb % (1 << H), mb / (1 << H) + mb % (1 << H)};
        gx = '{-1, -1, -1};
        gy = '{-1, -1, -1};
        pexp = 16'(sa * sb);
        sexp = a[7] ^ b[7];

        @(negedge clock);
        bus.start    = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.mul_done = spur;
        bus.mul_p    = 10'($urandom);
        @(posedge clock);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clock);
            bus.start    = 1'b0;
            bus.mul_done = 1'b0;
            if (abort_state >= 0 && int'(bus.state) == abort_state) begin
                reset_n = 1'b0;
                #1;
                chk_all_zero({name, "/abort"});
                return;
            end
            if (bus.busy !== 1'b1) busy_bad = 1'b1;
            if (bus.mul_go === 1'b1) begin
                if (nops < 3) begin
                    gx[nops] = int'(bus.mul_x);
                    gy[nops] = int'(bus.mul_y);
                    cur_l    = lat[nops];
                end
                nops++;
                pending = 1'b1;
                wcnt    = 0;
                if (spur) begin
                    bus.mul_done = 1'b1;
                    bus.mul_p    = 10'($urandom);
                end
            end else if (pending) begin
                wcnt++;
                if (nops <= 3 && (int'(bus.mul_x) != gx[nops-1] || int'(bus.mul_y) != gy[nops-1]))
                    stable_bad = 1'b1;
                if (wcnt == cur_l && nops <= 3) begin
                    bus.mul_done = 1'b1;
                    bus.mul_p    = 10'(gx[nops-1] * gy[nops-1]);
                    pending      = 1'b0;
                end
            end else if (bus.mul_x !== '0 || bus.mul_y !== '0) begin
                idle_bad = 1'b1;
            end
            if (pulse && int'(bus.state) == 5) bus.start = 1'b1;
            if (bus.done === 1'b1) begin
                done_cyc = cyc;
                if (pulse) bus.start = 1'b1;
                break;
            end
        end

        chk({name, "/done_cycle"}, 64'(done_cyc), 64'(1 + (1 + lhh) + (1 + lll) + (1 + lmid) + 3));
        chk({name, "/product"}, 64'(bus.product), 64'(pexp));
        chk({name, "/sinal"}, 64'(bus.sinal), 64'(sexp));
        chk({name, "/num_ops"}, 64'(nops), 64'd3);
        for (int k = 0; k < 3; k++) begin
            chk({name, "/op_x"}, 64'(gx[k]), 64'(ex[k]));
            chk({name, "/op_y"}, 64'(gy[k]), 64'(ey[k]));
        end
        chk({name, "/busy_during"}, 64'(busy_bad), 64'd0);
        chk({name, "/operand_hold"}, 64'(stable_bad), 64'd0);
        chk({name, "/operand_zero"}, 64'(idle_bad), 64'd0);

        @(negedge clock);
        bus.start = 1'b0;
        chk({name, "/post_state"}, 64'(bus.state), 64'd0);
        chk({name, "/post_busy"}, 64'(bus.busy), 64'd0);
        chk({name, "/post_done"}, 64'(bus.done), 64'd0);
        chk({name, "/hold_product"}, 64'(bus.product), 64'(pexp));
        @(negedge clock);
        chk({name, "/still_idle"}, 64'(bus.state), 64'd0);
        chk({name, "/hold_sinal"}, 64'(bus.sinal), 64'(sexp));
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.mul_p    = '0;
        bus.mul_done = 1'b0;

        #12;
        chk_all_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;

        run_op("basic",    8'h57, 8'h36, 1, 1, 1, 1'b0, 1'b0, -1);
        run_op("minneg",   8'h80, 8'h80, 1, 1, 1, 1'b0, 1'b0, -1);
        run_op("neg127",   8'hFF, 8'h7F, 1, 1, 1, 1'b0, 1'b0, -1);
        run_op("zero",     8'h00, 8'hFB, 1, 1, 1, 1'b0, 1'b0, -1);
        run_op("varlat",   8'hA5, 8'h3C, 3, 1, 5, 1'b1, 1'b0, -1);
        run_op("startpls", 8'h6B, 8'h92, 2, 2, 2, 1'b0, 1'b1, -1);
        run_op("after",    8'h7F, 8'h7F, 1, 2, 1, 1'b0, 1'b0, -1);

        run_op("abort",    8'h33, 8'hC4, 1, 1, 4, 1'b0, 1'b0, 7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("abort_hold/done", 64'(bus.done), 64'd0);
            chk("abort_hold/mul_go", 64'(bus.mul_go), 64'd0);
        end
        reset_n = 1'b1;
        run_op("post_rst", 8'h81, 8'h02, 1, 1, 1, 1'b0, 1'b0, -1);

        for (int i = 0; i < 30; i++) begin
            run_op("random", 8'($urandom), 8'($urandom),
                   int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                   int'($urandom_range(1, 4)), 1'($urandom), 1'b0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/karatsuba_sched.md
Name: karatsuba_sched

Overview:
- Sequencer for the signed (two's-complement) Karatsuba multiplier.
- Accepts a signed operand pair and converts it to magnitudes plus a result sign (sinal).
- Time-shares one external unsigned half-width multiplier across the three Karatsuba partial products (high, low, middle).
- Recombines the partial products, restores the sign and presents the 2*WIDTH product with a one-cycle done pulse.

Parameters:
WIDTH, 8, operand width in bits; must be even, >=4; H = WIDTH/2.

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
a  in  WIDTH  signed multiplicand, captured on the start edge
b  in  WIDTH  signed multiplier, captured on the start edge
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse; product valid
product  out  2*WIDTH  signed result; held until the next done
sinal  out  1  result sign, a[MSB]^b[MSB]
state  out  4  current state code, for debug
mul_go  out  1  one-cycle issue strobe to the shared multiplier
mul_x  out  H+1  unsigned multiplier operand x
mul_y  out  H+1  unsigned multiplier operand y
mul_p  in  2H+2  unsigned multiplier result
mul_done  in  1  multiplier result-valid strobe

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, and every output and internal register is 0. Reset mid-operation aborts with no done pulse and no further mul_go.
- State codes: IDLE=0, ABS=1, ISS_HH=2, WAIT_HH=3, ISS_LL=4, WAIT_LL=5, ISS_MID=6, WAIT_MID=7, COMBINE=8, SIGNFIX=9, DONE=10. Codes 11-15 go to IDLE on the next edge.
- IDLE: start=1 at an edge latches a and b, then goes to ABS. start in any other state is ignored.
- ABS (1 cycle):
  - ma=|a| and mb=|b| as unsigned WIDTH-bit values; -2^(WIDTH-1) maps to 2^(WIDTH-1).
  - sinal<=a[W-1]^b[W-1].
- ISS_xx (1 cycle): mul_go=1; mul_x and mul_y driven, zero-extended to H+1 bits.
  - HH: x=ma[W-1:H], y=mb[W-1:H].
  - LL: x=ma[H-1:0], y=mb[H-1:0].
  - MID: x=ma[W-1:H]+ma[H-1:0], y=mb[W-1:H]+mb[H-1:0], each H+1 bits with no truncation.
- Operand hold: mul_x and mul_y stay stable from ISS through the end of the matching WAIT. They are 0 in all other states.
- WAIT_xx: stays until mul_done=1. On that edge, mul_p is captured into phh, pll or pm and the FSM advances to the next ISS, or to COMBINE after MID.
  - mul_done is honoured only in WAIT states. It is ignored in the ISS cycle and everywhere else, so the minimum multiplier latency is 1.
- COMBINE (1 cycle), in 2*WIDTH+1 unsigned bits:
  - z1 = pm - phh - pll.
  - mag = (phh<<WIDTH) + (z1<<H) + pll.
- SIGNFIX (1 cycle): product_next = sinal ? -mag : mag, truncated to 2*WIDTH. Zero magnitude yields 0 regardless of sinal.
- DONE (1 cycle): product register updated, done=1, busy=1, then IDLE. start asserted during DONE is ignored; it must be re-sampled in IDLE.
- Latency: with the multiplier answering L cycles after mul_go (mul_done in the L-th WAIT cycle), done is high in cycle 7+3L after the start edge. For L=1 that is cycle 10.
- product and sinal hold their values between operations. sinal changes in ABS.

Test Plan:
- Basic, WIDTH=8, L=1: a=0x57 (87), b=0x36 (54) -> mul ops (5,3), (7,6), (12,9); product=0x125A (4698); sinal=0; done in cycle 10; busy high cycles 1-10.
- Most-negative operands: a=0x80, b=0x80 -> ops (8,8), (0,0), (8,8); product=0x4000 (16384); sinal=0.
- Signed result and zero: a=0xFF, b=0x7F -> product=0xFF81 (-127), sinal=1. Then a=0x00, b=0xFB -> product=0x0000, sinal=1.
- Variable latency: L=3 for HH, 1 for LL, 5 for MID, with spurious mul_done in the ISS cycles and in IDLE -> spurious strobes ignored; mul_x/mul_y stable through each wait; done in cycle 1+(1+3)+(1+1)+(1+5)+3; correct product.
- Start handling: pulse start in WAIT_LL and in DONE -> no restart and no extra done; a new start in IDLE is accepted normally.
- Reset mid-op: drop reset_n during WAIT_MID -> state=0 and all outputs 0 immediately, with no done. After reset_n rises, start with a=0x81, b=0x02 -> product=0xFF02 (-254).
